// File: rtl/cmp_pkg.sv
// cmp_pkg: shared definitions for the pipelined comparator.
//   cmp_op_t   - operation encoding carried on the op port
//   CMP_OP_W   - width of the op field
//   cmp_select - maps an op and the eq/gt/lt flags to a single result bit
package cmp_pkg;

    localparam int unsigned CMP_OP_W = 3;

    typedef enum logic [CMP_OP_W-1:0] {
        CMP_EQ   = 3'b000,
        CMP_GT   = 3'b001,
        CMP_LT   = 3'b010,
        CMP_ZERO = 3'b011,
        CMP_NE   = 3'b100,
        CMP_GE   = 3'b101,
        CMP_LE   = 3'b110,
        CMP_MAX  = 3'b111
    } cmp_op_t;

    // For CMP_ZERO the caller feeds b = 0, so eq means a == 0.
    // CMP_MAX has no boolean result and returns 0 here.
    function automatic logic cmp_select(cmp_op_t op, logic eq, logic gt, logic lt);
        logic r;
        r = 1'b0;
        case (op)
            CMP_EQ:   r = eq;
            CMP_GT:   r = gt;
            CMP_LT:   r = lt;
            CMP_ZERO: r = eq;
            CMP_NE:   r = !eq;
            CMP_GE:   r = !lt;
            CMP_LE:   r = !gt;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cmp_core.sv
// cmp_core: combinational magnitude comparator.
// Ports:
//   a, b       in  WIDTH  operands
//   is_signed  in  1      1 = two's-complement ordering, 0 = unsigned
//   eq, gt, lt out 1      exactly one is set for any operand pair
module cmp_core #(
    parameter int unsigned WIDTH = 6
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    always_comb begin
        eq = (a == b);
        lt = is_signed ? ($signed(a) < $signed(b)) : (a < b);
        gt = !eq && !lt;
    end

endmodule

// File: rtl/cmp_pipe_unit.sv
// cmp_pipe_unit: registered WIDTH-bit comparator with a valid/ready output stage
// and a running-maximum tracker.
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand beat handshake (in_ready is combinational)
//   a, b, op, is_signed   operands, cmp_pkg::cmp_op_t operation, signedness
//   max_clr               synchronous clear of the running maximum
//   out_valid / out_ready result handshake
//   result                0/1 zero-extended, or the tracked maximum for CMP_MAX
//   true_cnt              saturating count of accepted beats whose compare gave 1
// Build option: define CMP_CNT_EN to generate the true_cnt counter; otherwise
// true_cnt is tied to zero.
module cmp_pipe_unit
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             is_signed,
    input  logic             max_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] true_cnt
);

    cmp_op_t op_e;
    logic    accept;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             max_vld_q, max_vld_d;
    logic [WIDTH-1:0] max_val_q, max_val_d;

    logic [WIDTH-1:0] cmp_b;
    logic             flag_eq, flag_gt, flag_lt;
    logic             cmp_bit;
    logic             max_take;
    logic [WIDTH-1:0] max_next;

    assign op_e     = cmp_op_t'(op);
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // One comparator serves every op: MAX compares a against the tracked value,
    // ZERO compares a against zero, everything else compares a against b.
    always_comb begin
        cmp_b = b;
        if (op_e == CMP_MAX) begin
            cmp_b = max_val_q;
        end else if (op_e == CMP_ZERO) begin
            cmp_b = '0;
        end
    end

    cmp_core #(
        .WIDTH (WIDTH)
    ) u_cmp_core (
        .a         (a),
        .b         (cmp_b),
        .is_signed (is_signed),
        .eq        (flag_eq),
        .gt        (flag_gt),
        .lt        (flag_lt)
    );

    always_comb begin
        cmp_bit = cmp_select(op_e, flag_eq, flag_gt, flag_lt);

        // A concurrent max_clr empties the tracker before this beat is folded in.
        max_take = !(max_vld_q && !max_clr) || flag_gt;
        max_next = max_take ? a : max_val_q;

        out_valid_d = out_valid_q;
        result_d    = result_q;
        max_vld_d   = max_clr ? 1'b0 : max_vld_q;
        max_val_d   = max_val_q;

        if (accept) begin
            out_valid_d = 1'b1;
            if (op_e == CMP_MAX) begin
                max_val_d = max_next;
                max_vld_d = 1'b1;
                result_d  = max_next;
            end else begin
                result_d = {{(WIDTH-1){1'b0}}, cmp_bit};
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            max_vld_q   <= 1'b0;
            max_val_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            max_vld_q   <= max_vld_d;
            max_val_q   <= max_val_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;

`ifdef CMP_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (accept && (op_e != CMP_MAX) && cmp_bit && (cnt_q != '1)) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign true_cnt = cnt_q;
`else
    assign true_cnt = '0;
`endif

endmodule

// File: tb/tb_cmp_pipe_unit.sv
// tb_cmp_pipe_unit: directed bench for cmp_pipe_unit (WIDTH=6, CNT_W=8).
// Expected results are queued when a beat is accepted and popped when the
// result leaves the output stage.
module tb_cmp_pipe_unit;

    localparam int unsigned WIDTH = 6;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             is_signed;
    logic             max_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] true_cnt;

    cmp_pipe_unit #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .is_signed (is_signed),
        .max_clr   (max_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .true_cnt  (true_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_pops   = 0;
    int exp_cnt  = 0;
    int last_waits = 0;
    bit exact_lat = 1'b0;

    logic [WIDTH-1:0] exp_q[$];
    int               acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference compare using plain integer ordering.
    function automatic logic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic [2:0] mop, input logic ms);
        int va, vb;
        va = ms ? int'($signed(ma)) : int'(ma);
        vb = ms ? int'($signed(mb)) : int'(mb);
        case (mop)
            3'd0:    return va == vb;
            3'd1:    return va > vb;
            3'd2:    return va < vb;
            3'd3:    return ma == '0;
            3'd4:    return va != vb;
            3'd5:    return va >= vb;
            3'd6:    return va <= vb;
            default: return 1'b0;
        endcase
    endfunction

    // Output monitor: a result completes at the edge following this negedge.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(result), 32'hFFFF_FFFF);
            end else begin
                check("result", 32'(result), 32'(exp_q[0]));
                if (exact_lat) check("latency", 32'(cyc - acc_q[0]), 32'd1);
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
                n_pops++;
            end
        end
    end

    // Present one beat, wait (bounded) for acceptance, queue its expected result.
    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic [2:0] top, input logic ts, input logic tclr,
                        input logic [WIDTH-1:0] texp);
        int n;
        a = ta; b = tb; op = top; is_signed = ts; max_clr = tclr; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        last_waits = n;
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            exp_q.push_back(texp);
            acc_q.push_back(cyc);
            if (top != 3'd7 && texp[0] && exp_cnt != 255) exp_cnt++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        max_clr  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [31:0] cnt_expect();
`ifdef CMP_CNT_EN
        return 32'(exp_cnt);
`else
        return 32'd0;
`endif
    endfunction

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic [2:0]       rop;
        logic             rs;
        int               pops0;

        reset_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
        is_signed = 1'b0; max_clr = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_true_cnt", 32'(true_cnt), 32'd0);

        // Signed vs unsigned ordering and extremes.
        send(6'h3E, 6'h03, 3'd2, 1'b1, 1'b0, 6'd1);
        send(6'h3E, 6'h03, 3'd2, 1'b0, 1'b0, 6'd0);
        send(6'h3E, 6'h03, 3'd1, 1'b0, 1'b0, 6'd1);
        send(6'h3E, 6'h03, 3'd1, 1'b1, 1'b0, 6'd0);
        send(6'h20, 6'h1F, 3'd2, 1'b1, 1'b0, 6'd1);
        send(6'h20, 6'h1F, 3'd6, 1'b0, 1'b0, 6'd0);
        send(6'h20, 6'h20, 3'd5, 1'b1, 1'b0, 6'd1);
        send(6'h00, 6'h15, 3'd3, 1'b0, 1'b0, 6'd1);
        send(6'h01, 6'h00, 3'd3, 1'b1, 1'b0, 6'd0);
        send(6'h05, 6'h05, 3'd4, 1'b1, 1'b0, 6'd0);

        // Running maximum (signed).
        send(6'h3F, 6'h00, 3'd7, 1'b1, 1'b0, 6'h3F);
        send(6'h05, 6'h00, 3'd7, 1'b1, 1'b0, 6'h05);
        send(6'h02, 6'h00, 3'd7, 1'b1, 1'b0, 6'h05);
        send(6'h3C, 6'h00, 3'd7, 1'b1, 1'b1, 6'h3C);
        send(6'h3F, 6'h00, 3'd7, 1'b0, 1'b0, 6'h3F);
        drain();

        // Backpressure: EQ beat held while operands toggle.
        out_ready = 1'b0;
        send(6'd5, 6'd5, 3'd0, 1'b0, 1'b0, 6'd1);
        for (int i = 0; i < 4; i++) begin
            a = 6'($urandom); b = 6'($urandom); op = 3'($urandom_range(6));
            in_valid = 1'b1;
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_result", 32'(result), 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(6'd3, 6'd4, 3'd4, 1'b0, 1'b0, 6'd1);
        check("release_accept_wait", 32'(last_waits), 32'd0);
        drain();

        // Streaming: 16 back-to-back beats with exact one-cycle latency.
        exact_lat = 1'b1;
        pops0 = n_pops;
        for (int i = 0; i < 16; i++) begin
            ra = 6'($urandom); rb = 6'($urandom);
            rop = 3'($urandom_range(6)); rs = 1'($urandom);
            if (i % 4 == 0) rb = ra;
            send(ra, rb, rop, rs, 1'b0, {5'd0, model(ra, rb, rop, rs)});
            check("stream_no_stall", 32'(last_waits), 32'd0);
        end
        drain();
        exact_lat = 1'b0;
        check("stream_count", 32'(n_pops - pops0), 32'd16);
        check("cnt_mid", 32'(true_cnt), cnt_expect());

        // Async reset with a pending result; max tracker must be emptied too.
        send(6'h10, 6'h00, 3'd7, 1'b1, 1'b0, 6'h10);
        drain();
        out_ready = 1'b0;
        send(6'd1, 6'd1, 3'd0, 1'b0, 1'b0, 6'd1);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_result", 32'(result), 32'd0);
        check("async_rst_cnt", 32'(true_cnt), 32'd0);
        exp_q.delete();
        acc_q.delete();
        exp_cnt = 0;
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(6'h02, 6'h00, 3'd7, 1'b1, 1'b0, 6'h02);
        drain();

        // Counter saturation: 300 true beats.
        for (int i = 0; i < 300; i++) begin
            ra = 6'($urandom);
            send(ra, ra, 3'd0, 1'b0, 1'b0, 6'd1);
        end
        drain();
        check("cnt_sat_model", 32'(exp_cnt), 32'd255);
        check("cnt_sat", 32'(true_cnt), cnt_expect());
        send(6'h3F, 6'h00, 3'd7, 1'b0, 1'b0, 6'h3F);
        drain();
        check("cnt_after_max", 32'(true_cnt), cnt_expect());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: sim time 2000000 reached, expected $finish earlier");
        $fatal(1, "timeout");
    end

endmodule
